spi_display_receiver: RTL and testbench

- SPI slave receiver for the MAX7219 command protocol: the display end of the stopwatch's SPI link.
- Captures 16-bit frames on MOSI/clk_SPI/CS and decodes them into the MAX7219 register set: 8 digit registers, decode mode, intensity, scan limit, shutdown and display test.
- Used as an on-chip loopback and scoreboard target for the SPI driver. It can also drive a local display model.

---
 rtl/spi_display_receiver.sv | 180 ++++++++++++++++++
 tb/tb_spi_display_receiver.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/spi_display_receiver.sv
// rtl/spi_display_receiver.sv - MAX7219-style SPI slave receiver decoding frames into the display register set
// Optional DOUT daisy-chain output enabled by defining SPI_DISPLAY_RECEIVER_DOUT_EN.
module spi_display_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        MOSI,
    input  logic        CS,
    input  logic        clk_SPI,
    output logic [63:0] digit_data,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        display_test,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        dout
);

    // Only address/data bits are kept unless DOUT needs the full 16-bit delay line
`ifdef SPI_DISPLAY_RECEIVER_DOUT_EN
    localparam int SHIFT_W = 16;
`else
    localparam int SHIFT_W = 12;
`endif

    typedef enum logic {IDLE, SHIFT} state_e;

    logic [SYNC_STAGES-1:0] mosi_sync_q, cs_sync_q, sclk_sync_q;
    logic                   cs_hist_q, sclk_hist_q;
    logic                   mosi_s, cs_s, sclk_s;
    logic                   cs_fall, cs_rise, sclk_rise;

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 latch, abort;

    logic [63:0] digit_q, digit_d;
    logic [7:0]  decode_q, decode_d;
    logic [3:0]  intensity_q, intensity_d;
    logic [2:0]  scan_q, scan_d;
    logic        shdn_q, shdn_d;
    logic        test_q, test_d;
    logic        fv_q, fe_q;

    // CS chain resets low so a CS already low at reset release never looks like a falling edge
    always_ff @(posedge clk) begin
        if (res) begin
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            cs_hist_q   <= 1'b0;
            sclk_hist_q <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], clk_SPI};
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign sclk_rise = sclk_s & ~sclk_hist_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = 5'd0;
                end
            end
            SHIFT: begin
                // CS edge wins over a coincident clock edge; the count is the pre-cycle one
                if (cs_rise) begin
                    state_d = IDLE;
                    latch   = (cnt_q == 5'd16);
                    abort   = (cnt_q != 5'd0) && (cnt_q != 5'd16);
                end else if (sclk_rise) begin
                    shift_d = {shift_q[SHIFT_W-2:0], mosi_s};
                    cnt_d   = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        digit_d     = digit_q;
        decode_d    = decode_q;
        intensity_d = intensity_q;
        scan_d      = scan_q;
        shdn_d      = shdn_q;
        test_d      = test_q;
        if (latch) begin
            for (int n = 0; n < 8; n++) begin
                if (shift_q[11:8] == 4'(n + 1)) digit_d[8*n +: 8] = shift_q[7:0];
            end
            case (shift_q[11:8])
                4'h9:    decode_d    = shift_q[7:0];
                4'hA:    intensity_d = shift_q[3:0];
                4'hB:    scan_d      = shift_q[2:0];
                4'hC:    shdn_d      = shift_q[0];
                4'hF:    test_d      = shift_q[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= 5'd0;
            digit_q     <= '0;
            decode_q    <= '0;
            intensity_q <= '0;
            scan_q      <= '0;
            shdn_q      <= 1'b0;
            test_q      <= 1'b0;
            fv_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            decode_q    <= decode_d;
            intensity_q <= intensity_d;
            scan_q      <= scan_d;
            shdn_q      <= shdn_d;
            test_q      <= test_d;
            fv_q        <= latch;
            fe_q        <= abort;
        end
    end

`ifdef SPI_DISPLAY_RECEIVER_DOUT_EN
    logic sclk_fall;
    logic dout_q;

    assign sclk_fall = ~sclk_s & sclk_hist_q;

    always_ff @(posedge clk) begin
        if (res || state_q == IDLE) begin
            dout_q <= 1'b0;
        end else if (sclk_fall) begin
            dout_q <= shift_q[15];
        end
    end

    assign dout = dout_q;
`else
    assign dout = 1'b0;
`endif

    assign digit_data   = digit_q;
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_q;
    assign shutdown_n   = shdn_q;
    assign display_test = test_q;
    assign frame_valid  = fv_q;
    assign frame_error  = fe_q;

endmodule

// File: tb/tb_spi_display_receiver.sv
// tb/tb_spi_display_receiver.sv - directed self-checking bench for spi_display_receiver
module tb_spi_display_receiver;

    logic        clk = 1'b0;
    logic        res, MOSI, CS, clk_SPI;
    logic [63:0] digit_data;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n, display_test, frame_valid, frame_error, dout;

    int          checks = 0;
    int          errors = 0;
    int          fv_cnt = 0;
    int          fe_cnt = 0;
    logic [31:0] dout_hist = '0;
    logic [31:0] dout_exp;

    spi_display_receiver #(.SYNC_STAGES(2)) dut (
        .clk(clk), .res(res), .MOSI(MOSI), .CS(CS), .clk_SPI(clk_SPI),
        .digit_data(digit_data), .decode_mode(decode_mode), .intensity(intensity),
        .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test),
        .frame_valid(frame_valid), .frame_error(frame_error), .dout(dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_error) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drops CS and clocks n bits MSB-first; CS is left low
    task automatic spi_bits(input logic [31:0] data, input int n);
        @(negedge clk);
        CS = 1'b0;
        wait_clk(4);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = data[i];
            wait_clk(2);
            clk_SPI = 1'b1;
            wait_clk(4);
            clk_SPI = 1'b0;
            wait_clk(4);
            dout_hist = {dout_hist[30:0], dout};
        end
    endtask

    task automatic frame(input logic [31:0] data, input int n);
        spi_bits(data, n);
        CS = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        res = 1'b1; MOSI = 1'b0; CS = 1'b1; clk_SPI = 1'b0;
        wait_clk(5);
        res = 1'b0;
        wait_clk(4);
        chk("rst_digits", digit_data, 64'h0);
        chk("rst_decode", decode_mode, 8'h0);
        chk("rst_intensity", intensity, 4'h0);
        chk("rst_scan", scan_limit, 3'h0);
        chk("rst_shutdown_n", shutdown_n, 1'b0);
        chk("rst_test", display_test, 1'b0);
        chk("rst_pulses", {frame_valid, frame_error, dout}, 3'b000);

        // Latency: CS rises at a negedge, valid appears after the third posedge
        spi_bits(32'h0C01, 16);
        CS = 1'b1;
        wait_clk(2);
        chk("lat_fv_early", frame_valid, 1'b0);
        chk("lat_shdn_early", shutdown_n, 1'b0);
        wait_clk(1);
        chk("lat_fv", frame_valid, 1'b1);
        chk("lat_shdn", shutdown_n, 1'b1);
        wait_clk(1);
        chk("lat_fv_drop", frame_valid, 1'b0);
        wait_clk(6);
        chk("f1_fv_cnt", fv_cnt, 1);
        chk("f1_others", {digit_data, decode_mode, intensity, scan_limit, display_test}, 80'h0);

        frame(32'h0105, 16);
        frame(32'h087F, 16);
        chk("digits_1_8", digit_data, 64'h7F00_0000_0000_0005);
        frame(32'h0A1F, 16);
        chk("intensity", intensity, 4'hF);
        chk("f4_fv_cnt", fv_cnt, 4);

        frame(32'h00AB_0309, 24);
        chk("burst24_digits", digit_data, 64'h7F00_0000_0009_0005);
        chk("burst24_fv_cnt", fv_cnt, 5);
        frame(32'h0A, 8);
        chk("short_fe_cnt", fe_cnt, 1);
        chk("short_fv_cnt", fv_cnt, 5);
        chk("short_intensity", intensity, 4'hF);

        frame(32'h0, 0);
        chk("empty_fv_cnt", fv_cnt, 5);
        chk("empty_fe_cnt", fe_cnt, 1);
        frame(32'h0DFF, 16);
        chk("noop_fv_cnt", fv_cnt, 6);
        chk("noop_regs", {digit_data, decode_mode, intensity, scan_limit, shutdown_n, display_test},
            {64'h7F00_0000_0009_0005, 8'h00, 4'hF, 3'h0, 1'b1, 1'b0});

        // Reset in the middle of a 0x0F01 frame, CS still low at release
        spi_bits(32'h1E, 9);
        res = 1'b1;
        wait_clk(4);
        res = 1'b0;
        wait_clk(2);
        CS = 1'b1;
        wait_clk(8);
        chk("midrst_fv_cnt", fv_cnt, 6);
        chk("midrst_fe_cnt", fe_cnt, 1);
        frame(32'h0B07, 16);
        chk("midrst_scan", scan_limit, 3'h7);
        chk("midrst_test", display_test, 1'b0);
        chk("midrst_cleared", {digit_data, intensity, shutdown_n}, 69'h0);
        chk("midrst_fe_cnt2", fe_cnt, 1);
        chk("midrst_fv_cnt2", fv_cnt, 7);

        // Two frames in one CS window: DOUT replays the first 16 bits after 16 clocks
        dout_hist = '0;
        frame(32'h1234_0000, 32);
`ifdef SPI_DISPLAY_RECEIVER_DOUT_EN
        dout_exp = 32'h0000_2468;
`else
        dout_exp = 32'h0;
`endif
        chk("dout_stream", dout_hist, dout_exp);
        chk("dout_idle", dout, 1'b0);
        chk("chain_fv_cnt", fv_cnt, 8);
        chk("chain_scan", scan_limit, 3'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
